// File: rtl/embertrail_issue_seq_if.sv
// ----------------------------------------------------------------------------
// embertrail_issue_seq_if
//   Bundles the fetch and issue handshake signals of the EmberTrail issue
//   sequencer.
//
//   Signals (direction as seen from the sequencer, modport master):
//     oFetchReq      out  fetch request, held until iFetchAck
//     oFetchAddr     out  fetch address (16-bit halfword units), equals oPC
//     iFetchAck      in   iFetchData valid; completes the fetch
//     iFetchData     in   fetched packet (slot 1 in [15:0], slot 2 / ext in [31:16])
//     oIR            out  packet presented to the control unit
//     oIssueValid    out  oIR / oSlotMask valid
//     oSlotMask      out  bit0 slot 1 enabled, bit1 slot 2 enabled
//     iStall         in   downstream hold
//     iBranchTaken   in   redirect request, used only in an issue-accept cycle
//     iBranchTarget  in   redirect halfword address
//     oPC            out  address of the packet currently held
//
//   Modports: master = sequencer, slave = fetch unit / control unit side.
// ----------------------------------------------------------------------------
interface embertrail_issue_seq_if;
    logic        oFetchReq;
    logic [15:0] oFetchAddr;
    logic        iFetchAck;
    logic [31:0] iFetchData;
    logic [31:0] oIR;
    logic        oIssueValid;
    logic [1:0]  oSlotMask;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic [15:0] oPC;

    modport master (
        output oFetchReq, oFetchAddr, oIR, oIssueValid, oSlotMask, oPC,
        input  iFetchAck, iFetchData, iStall, iBranchTaken, iBranchTarget
    );

    modport slave (
        input  oFetchReq, oFetchAddr, oIR, oIssueValid, oSlotMask, oPC,
        output iFetchAck, iFetchData, iStall, iBranchTaken, iBranchTarget
    );
endinterface

// File: rtl/embertrail_issue_seq.sv
// ----------------------------------------------------------------------------
// embertrail_issue_seq
//   Fetch/issue sequencer for the dual-slot EmberTrail packet format. Fetches
//   one 32-bit packet at oPC, presents it to the control unit with a slot
//   mask, and advances oPC by the packet length (1 or 2 halfwords) or to a
//   taken branch target. Extended packets (LDA / BEQ) only ever enable slot 1.
//
//   Ports:
//     iClock    in   sole clock, rising edge
//     iReset_n  in   synchronous active-low reset
//     bus       embertrail_issue_seq_if.master (fetch + issue handshake)
//
//   Configuration:
//     EMBERTRAIL_HAZARD_SPLIT_EN  when defined, a dual packet whose slot 2
//       reads the register written by slot 1 is issued in two steps
//       (mask 01, then mask 10 from the SPLIT state). When undefined, such
//       packets issue both slots together and SPLIT is never entered.
//
//   All outputs come straight from flops.
// ----------------------------------------------------------------------------
module embertrail_issue_seq (
    input  logic                   iClock,
    input  logic                   iReset_n,
    embertrail_issue_seq_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        SPLIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        fetch_req_q, fetch_req_d;
    logic        issue_valid_q, issue_valid_d;
    logic [1:0]  slot_mask_q, slot_mask_d;

    logic [15:0] next_pc;
    logic        hazard;

    // LDA and BEQ carry an operand in the upper halfword instead of slot 2.
    function automatic logic pkt_is_ext(input logic [31:0] p);
        return (p[3:0] == 4'b1001) || (p[3:0] == 4'b1111);
    endfunction

    function automatic logic [15:0] pkt_len(input logic [31:0] p);
        return (p[15] || pkt_is_ext(p)) ? 16'd2 : 16'd1;
    endfunction

`ifdef EMBERTRAIL_HAZARD_SPLIT_EN
    // Slot 2 would read a register that slot 1 writes in the same packet.
    // MVI and immediate-B forms do not read B2.
    function automatic logic pkt_hazard(input logic [31:0] p);
        logic wb1;
        logic b2_used;
        wb1     = (p[3:0] != 4'd0) && (p[3:0] <= 4'd13);
        b2_used = !p[30] && (p[19:16] != 4'b0111);
        return p[15] && !pkt_is_ext(p) && wb1 &&
               ((p[8:4] == p[24:20]) || (b2_used && (p[8:4] == p[29:25])));
    endfunction
`endif

    // Slot mask for the first issue of a freshly fetched packet.
    function automatic logic [1:0] pkt_mask(input logic [31:0] p);
        logic single;
        single = !p[15] || pkt_is_ext(p);
`ifdef EMBERTRAIL_HAZARD_SPLIT_EN
        single = single || pkt_hazard(p);
`endif
        return single ? 2'b01 : 2'b11;
    endfunction

    // Wraps modulo 2^16.
    assign next_pc = pc_q + pkt_len(ir_q);

`ifdef EMBERTRAIL_HAZARD_SPLIT_EN
    assign hazard = pkt_hazard(ir_q);
`else
    assign hazard = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        fetch_req_d   = fetch_req_q;
        issue_valid_d = issue_valid_q;
        slot_mask_d   = slot_mask_q;

        case (state_q)
            FETCH: begin
                // The request rises one cycle after reset; an ack is only
                // taken once the request is actually visible on the bus.
                fetch_req_d = 1'b1;
                if (fetch_req_q && bus.iFetchAck) begin
                    ir_d          = bus.iFetchData;
                    fetch_req_d   = 1'b0;
                    issue_valid_d = 1'b1;
                    slot_mask_d   = pkt_mask(bus.iFetchData);
                    state_d       = ISSUE;
                end
            end

            ISSUE: begin
                if (!bus.iStall) begin
                    if (bus.iBranchTaken) begin
                        // Redirect squashes any pending slot-2 issue.
                        pc_d          = bus.iBranchTarget;
                        state_d       = FETCH;
                        fetch_req_d   = 1'b1;
                        issue_valid_d = 1'b0;
                        slot_mask_d   = 2'b00;
                    end else if (hazard) begin
                        state_d     = SPLIT;
                        slot_mask_d = 2'b10;
                    end else begin
                        pc_d          = next_pc;
                        state_d       = FETCH;
                        fetch_req_d   = 1'b1;
                        issue_valid_d = 1'b0;
                        slot_mask_d   = 2'b00;
                    end
                end
            end

`ifdef EMBERTRAIL_HAZARD_SPLIT_EN
            SPLIT: begin
                // Branch requests are not honoured here; slot 1 already issued.
                if (!bus.iStall) begin
                    pc_d          = next_pc;
                    state_d       = FETCH;
                    fetch_req_d   = 1'b1;
                    issue_valid_d = 1'b0;
                    slot_mask_d   = 2'b00;
                end
            end
`endif

            default: begin
                state_d       = FETCH;
                fetch_req_d   = 1'b1;
                issue_valid_d = 1'b0;
                slot_mask_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state_q       <= FETCH;
            pc_q          <= 16'h0000;
            ir_q          <= 32'h0000_0000;
            fetch_req_q   <= 1'b0;
            issue_valid_q <= 1'b0;
            slot_mask_q   <= 2'b00;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            fetch_req_q   <= fetch_req_d;
            issue_valid_q <= issue_valid_d;
            slot_mask_q   <= slot_mask_d;
        end
    end

    assign bus.oFetchReq   = fetch_req_q;
    assign bus.oFetchAddr  = pc_q;
    assign bus.oPC         = pc_q;
    assign bus.oIR         = ir_q;
    assign bus.oIssueValid = issue_valid_q;
    assign bus.oSlotMask   = slot_mask_q;

endmodule

// File: tb/tb_embertrail_issue_seq.sv
// ----------------------------------------------------------------------------
// tb_embertrail_issue_seq
//   Directed scenarios plus a randomized run against a transaction-level
//   model of the sequencer (expected PC and queue of slot masks per packet).
//   Honours EMBERTRAIL_HAZARD_SPLIT_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_embertrail_issue_seq;

`ifdef EMBERTRAIL_HAZARD_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   nchk  = 0;
    int   npass = 0;
    int   nfail = 0;

    embertrail_issue_seq_if bus ();

    embertrail_issue_seq dut (
        .iClock   (clk),
        .iReset_n (rst_n),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference rules ----------------
    function automatic bit m_ext(input logic [31:0] p);
        return (p[3:0] == 4'd9) || (p[3:0] == 4'd15);
    endfunction

    function automatic logic [15:0] m_len(input logic [31:0] p);
        return (p[15] || m_ext(p)) ? 16'd2 : 16'd1;
    endfunction

    function automatic bit m_hazard(input logic [31:0] p);
        bit b2_used;
        if (!SPLIT_EN || !p[15] || m_ext(p)) return 1'b0;
        if (p[3:0] == 4'd0 || p[3:0] > 4'd13) return 1'b0;
        b2_used = !p[30] && (p[19:16] != 4'd7);
        return (p[8:4] == p[24:20]) || (b2_used && (p[8:4] == p[29:25]));
    endfunction

    // Number of issue cycles and their masks for one packet.
    function automatic int m_issues(input logic [31:0] p, output logic [1:0] m0);
        if (m_hazard(p)) begin
            m0 = 2'b01;
            return 2;
        end
        m0 = (!p[15] || m_ext(p)) ? 2'b01 : 2'b11;
        return 1;
    endfunction

    function automatic logic [31:0] rand_pkt();
        logic [31:0] p;
        p = $urandom;
        if ($urandom_range(0, 2) == 0) begin
            p[15]    = 1'b1;
            p[3:0]   = 4'($urandom_range(1, 13));
            p[24:20] = p[8:4];
        end
        return p;
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus.iFetchAck     = 1'b0;
        bus.iFetchData    = 32'h0;
        bus.iStall        = 1'b0;
        bus.iBranchTaken  = 1'b0;
        bus.iBranchTarget = 16'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bus.oFetchReq === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Returns at the negedge of the first issue cycle.
    task automatic fetch(input logic [31:0] d, output bit ok);
        wait_req(ok);
        bus.iFetchAck  = 1'b1;
        bus.iFetchData = d;
        @(negedge clk);
        bus.iFetchAck  = 1'b0;
        bus.iFetchData = 32'h0;
    endtask

    task automatic goto_pc(input logic [15:0] t);
        bit ok;
        fetch(32'h0000_000F, ok);
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = t;
        @(negedge clk);
        bus.iBranchTaken  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        nchk++; if (bus.oFetchReq !== 1'b0) begin nfail++; $display("FAIL rst_req: got %b want 0", bus.oFetchReq); end else npass++;
        nchk++; if (bus.oIssueValid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %b want 0", bus.oIssueValid); end else npass++;
        nchk++; if (bus.oSlotMask !== 2'b00) begin nfail++; $display("FAIL rst_mask: got %b want 00", bus.oSlotMask); end else npass++;
        nchk++; if (bus.oPC !== 16'h0000) begin nfail++; $display("FAIL rst_pc: got %h want 0000", bus.oPC); end else npass++;
        nchk++; if (bus.oIR !== 32'h0) begin nfail++; $display("FAIL rst_ir: got %h want 00000000", bus.oIR); end else npass++;
        rst_n = 1'b1;
        @(negedge clk);
        nchk++; if ({bus.oFetchReq, bus.oFetchAddr} !== {1'b1, 16'h0000}) begin nfail++; $display("FAIL first_req: got %h want %h", {bus.oFetchReq, bus.oFetchAddr}, {1'b1, 16'h0000}); end else npass++;
    endtask

    task automatic test_first_issue();
        bus.iFetchAck  = 1'b1;
        bus.iFetchData = 32'h0000_0001;
        @(negedge clk);
        bus.iFetchAck  = 1'b0;
        nchk++; if ({bus.oIssueValid, bus.oFetchReq, bus.oIR, bus.oSlotMask} !== {1'b1, 1'b0, 32'h1, 2'b01}) begin nfail++; $display("FAIL first_issue: got %h want %h", {bus.oIssueValid, bus.oFetchReq, bus.oIR, bus.oSlotMask}, {1'b1, 1'b0, 32'h1, 2'b01}); end else npass++;
        @(negedge clk);
        nchk++; if ({bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr} !== {1'b1, 1'b0, 16'h0001}) begin nfail++; $display("FAIL first_next: got %h want %h", {bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr}, {1'b1, 1'b0, 16'h0001}); end else npass++;
    endtask

    task automatic test_dual_no_hazard();
        bit ok;
        goto_pc(16'h0010);
        nchk++; if ({bus.oFetchReq, bus.oFetchAddr} !== {1'b1, 16'h0010}) begin nfail++; $display("FAIL dual_addr: got %h want %h", {bus.oFetchReq, bus.oFetchAddr}, {1'b1, 16'h0010}); end else npass++;
        fetch(32'h0012_8021, ok);
        nchk++; if (ok !== 1'b1) begin nfail++; $display("FAIL dual_fetch_timeout: got %b want 1", ok); end else npass++;
        nchk++; if ({bus.oIssueValid, bus.oSlotMask, bus.oIR} !== {1'b1, 2'b11, 32'h0012_8021}) begin nfail++; $display("FAIL dual_issue: got %h want %h", {bus.oIssueValid, bus.oSlotMask, bus.oIR}, {1'b1, 2'b11, 32'h0012_8021}); end else npass++;
        @(negedge clk);
        nchk++; if ({bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr} !== {1'b1, 1'b0, 16'h0012}) begin nfail++; $display("FAIL dual_next: got %h want %h", {bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr}, {1'b1, 1'b0, 16'h0012}); end else npass++;
    endtask

    task automatic test_hazard_split();
        bit ok;
        logic [1:0] m0;
        int n;
        logic [31:0] pkt = 32'h0022_8021;
        fetch(pkt, ok);
        n = m_issues(pkt, m0);
        for (int k = 0; k < n; k++) begin
            logic [1:0] em = (k == 0) ? m0 : 2'b10;
            nchk++; if ({bus.oIssueValid, bus.oSlotMask, bus.oIR, bus.oPC} !== {1'b1, em, pkt, 16'h0012}) begin nfail++; $display("FAIL haz_issue%0d: got %h want %h", k, {bus.oIssueValid, bus.oSlotMask, bus.oIR, bus.oPC}, {1'b1, em, pkt, 16'h0012}); end else npass++;
            // A branch request during the second step must be ignored.
            if (k == 1) begin
                bus.iBranchTaken  = 1'b1;
                bus.iBranchTarget = 16'h0BAD;
            end
            @(negedge clk);
        end
        bus.iBranchTaken = 1'b0;
        nchk++; if ({bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr} !== {1'b1, 1'b0, 16'h0014}) begin nfail++; $display("FAIL haz_next: got %h want %h", {bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr}, {1'b1, 1'b0, 16'h0014}); end else npass++;
    endtask

    task automatic test_branch();
        bit ok;
        fetch(32'h0040_000F, ok);
        nchk++; if ({bus.oIssueValid, bus.oSlotMask} !== {1'b1, 2'b01}) begin nfail++; $display("FAIL beq_issue: got %b want %b", {bus.oIssueValid, bus.oSlotMask}, {1'b1, 2'b01}); end else npass++;
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'h0100;
        @(negedge clk);
        bus.iBranchTaken  = 1'b0;
        nchk++; if ({bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr} !== {1'b1, 1'b0, 16'h0100}) begin nfail++; $display("FAIL beq_target: got %h want %h", {bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr}, {1'b1, 1'b0, 16'h0100}); end else npass++;
    endtask

    task automatic test_stall();
        bit ok;
        fetch(32'h0012_8021, ok);
        // Held issue: branch and stray acks must have no effect.
        bus.iStall        = 1'b1;
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'h0300;
        bus.iFetchAck     = 1'b1;
        bus.iFetchData    = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchk++; if ({bus.oIssueValid, bus.oFetchReq, bus.oIR, bus.oSlotMask, bus.oPC} !== {1'b1, 1'b0, 32'h0012_8021, 2'b11, 16'h0100}) begin nfail++; $display("FAIL stall_hold%0d: got %h want %h", i, {bus.oIssueValid, bus.oFetchReq, bus.oIR, bus.oSlotMask, bus.oPC}, {1'b1, 1'b0, 32'h0012_8021, 2'b11, 16'h0100}); end else npass++;
        end
        idle_inputs();
        @(negedge clk);
        nchk++; if ({bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr} !== {1'b1, 1'b0, 16'h0102}) begin nfail++; $display("FAIL stall_release: got %h want %h", {bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr}, {1'b1, 1'b0, 16'h0102}); end else npass++;
    endtask

    task automatic test_extended();
        bit ok;
        // LDA with dual bit and matching A1/A2: still single issue, length 2.
        fetch(32'h0020_8029, ok);
        nchk++; if ({bus.oIssueValid, bus.oSlotMask} !== {1'b1, 2'b01}) begin nfail++; $display("FAIL ext_issue: got %b want %b", {bus.oIssueValid, bus.oSlotMask}, {1'b1, 2'b01}); end else npass++;
        @(negedge clk);
        nchk++; if ({bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr} !== {1'b1, 1'b0, 16'h0104}) begin nfail++; $display("FAIL ext_next: got %h want %h", {bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr}, {1'b1, 1'b0, 16'h0104}); end else npass++;
    endtask

    task automatic test_wrap();
        bit ok;
        goto_pc(16'hFFFF);
        fetch(32'h0012_8021, ok);
        nchk++; if ({bus.oSlotMask, bus.oPC} !== {2'b11, 16'hFFFF}) begin nfail++; $display("FAIL wrap_issue: got %h want %h", {bus.oSlotMask, bus.oPC}, {2'b11, 16'hFFFF}); end else npass++;
        @(negedge clk);
        nchk++; if (bus.oFetchAddr !== 16'h0001) begin nfail++; $display("FAIL wrap_dual: got %h want 0001", bus.oFetchAddr); end else npass++;
        goto_pc(16'hFFFF);
        fetch(32'h0000_0001, ok);
        @(negedge clk);
        nchk++; if (bus.oFetchAddr !== 16'h0000) begin nfail++; $display("FAIL wrap_single: got %h want 0000", bus.oFetchAddr); end else npass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        goto_pc(16'h0040);
        fetch(32'h0022_8021, ok);
        @(negedge clk);
        // Now in the second issue step (split build) or fetching at 0x0042.
        rst_n         = 1'b0;
        bus.iStall    = 1'b1;
        bus.iFetchAck = 1'b1;
        @(negedge clk);
        nchk++; if ({bus.oFetchReq, bus.oIssueValid, bus.oSlotMask, bus.oPC, bus.oIR} !== {1'b0, 1'b0, 2'b00, 16'h0, 32'h0}) begin nfail++; $display("FAIL midrst_state: got %h want %h", {bus.oFetchReq, bus.oIssueValid, bus.oSlotMask, bus.oPC, bus.oIR}, {1'b0, 1'b0, 2'b00, 16'h0, 32'h0}); end else npass++;
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        nchk++; if ({bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr} !== {1'b1, 1'b0, 16'h0000}) begin nfail++; $display("FAIL midrst_refetch: got %h want %h", {bus.oFetchReq, bus.oIssueValid, bus.oFetchAddr}, {1'b1, 1'b0, 16'h0000}); end else npass++;
        @(negedge clk);
        nchk++; if (bus.oIssueValid !== 1'b0) begin nfail++; $display("FAIL midrst_noissue: got %b want 0", bus.oIssueValid); end else npass++;
    endtask

    task automatic test_random();
        logic [15:0] mpc = 16'h0000;
        logic [31:0] pkt = 32'h0;
        logic [1:0]  q[$];
        logic [1:0]  m0;
        bit          busy = 1'b0;
        bit          first = 1'b0;
        int          n;
        logic        ack, stall, br;
        logic [15:0] tgt;
        logic [31:0] data;
        do_reset();
        rst_n = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!busy) begin
                nchk++; if ({bus.oIssueValid, bus.oFetchReq, bus.oFetchAddr} !== {1'b0, 1'b1, mpc}) begin nfail++; $display("FAIL rnd_fetch c%0d: got %h want %h", cyc, {bus.oIssueValid, bus.oFetchReq, bus.oFetchAddr}, {1'b0, 1'b1, mpc}); end else npass++;
            end else begin
                nchk++; if ({bus.oIssueValid, bus.oFetchReq, bus.oIR, bus.oSlotMask, bus.oPC} !== {1'b1, 1'b0, pkt, q[0], mpc}) begin nfail++; $display("FAIL rnd_issue c%0d: got %h want %h", cyc, {bus.oIssueValid, bus.oFetchReq, bus.oIR, bus.oSlotMask, bus.oPC}, {1'b1, 1'b0, pkt, q[0], mpc}); end else npass++;
            end
            ack   = ($urandom_range(0, 2) == 0);
            data  = rand_pkt();
            stall = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 4) == 0);
            tgt   = 16'($urandom);
            bus.iFetchAck     = ack;
            bus.iFetchData    = data;
            bus.iStall        = stall;
            bus.iBranchTaken  = br;
            bus.iBranchTarget = tgt;
            if (!busy) begin
                if (ack) begin
                    busy  = 1'b1;
                    first = 1'b1;
                    pkt   = data;
                    q.delete();
                    n = m_issues(data, m0);
                    q.push_back(m0);
                    if (n == 2) q.push_back(2'b10);
                end
            end else if (!stall) begin
                if (first && br) begin
                    mpc  = tgt;
                    busy = 1'b0;
                    q.delete();
                end else begin
                    void'(q.pop_front());
                    first = 1'b0;
                    if (q.size() == 0) begin
                        mpc  = mpc + m_len(pkt);
                        busy = 1'b0;
                    end
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_first_issue();
        test_dual_no_hazard();
        test_hazard_split();
        test_branch();
        test_stall();
        test_extended();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/embertrail_issue_seq.md
EMBERTRAIL_ISSUE_SEQ -- requirements
Module: embertrail_issue_seq

Interface
REQ-001 iClock  in  1  sole clock; all state updates on rising edge.
REQ-002 iReset_n  in  1  synchronous, active-low reset, sampled on iClock rising edge.
REQ-003 oFetchReq  out  1  instruction fetch request, held until acknowledged.
REQ-004 oFetchAddr  out  16  fetch address in 16-bit-halfword units; equals oPC.
REQ-005 iFetchAck  in  1  iFetchData valid this cycle; completes the fetch.
REQ-006 iFetchData  in  32  fetched packet; bits [15:0] slot 1, bits [31:16] slot 2 or extended operand.
REQ-007 oIR  out  32  packet presented to the control unit.
REQ-008 oIssueValid  out  1  oIR/oSlotMask valid this cycle.
REQ-009 oSlotMask  out  2  bit0 = slot 1 enabled, bit1 = slot 2 enabled.
REQ-010 iStall  in  1  downstream hold; an issue is accepted only when oIssueValid=1 and iStall=0.
REQ-011 iBranchTaken  in  1  redirect request, qualified only in an issue-accept cycle.
REQ-012 iBranchTarget  in  16  redirect halfword address.
REQ-013 oPC  out  16  address of the packet currently held.

Function
REQ-014 Decode of latched packet: op1=[3:0], A1=[8:4], B1=[13:9], B1imm=[14], dual=[15], op2=[19:16], A2=[24:20], B2=[29:25], B2imm=[30].
REQ-015 Extended packet: op1 = 4'b1001 (LDA) or 4'b1111 (BEQ); slot 2 is never enabled; dual bit is ignored.
REQ-016 Packet length: 2 halfwords if dual=1 or extended, else 1; sequential next PC = oPC + length, modulo 2^16 (0xFFFF+2 -> 0x0001).
REQ-017 Slot-1 writeback: op1 in 1..13.
REQ-018 Slot-2 source usage: A2 always; B2 only when B2imm=0 and op2 != 4'b0111 (MVI).
REQ-019 Hazard: dual, non-extended packet, slot-1 writeback true, and A1 equals A2 or a used B2.
REQ-020 FSM states: FETCH, ISSUE, SPLIT.
REQ-021 FETCH: oFetchReq=1, oIssueValid=0; on iFetchAck latch iFetchData into oIR and go to ISSUE next cycle.
REQ-022 ISSUE: oIssueValid=1; oSlotMask = 2'b01 if hazard, single or extended packet, else 2'b11.
REQ-023 ISSUE hold: while iStall=1, oIR, oSlotMask and oPC are held unchanged.
REQ-024 ISSUE accept with iBranchTaken=1: oPC <= iBranchTarget; go to FETCH; slot 2 of the packet is squashed.
REQ-025 ISSUE accept, no branch, hazard: go to SPLIT; oPC unchanged.
REQ-026 ISSUE accept, no branch, no hazard: oPC <= next PC; go to FETCH.
REQ-027 SPLIT: oIssueValid=1, oSlotMask=2'b10, same oIR; hold while iStall=1.
REQ-028 SPLIT accept: oPC <= next PC; go to FETCH; iBranchTaken is ignored in SPLIT.
REQ-029 Throughput: at most one accepted issue per cycle; minimum 2 cycles per packet (fetch then issue).
REQ-030 iFetchAck outside FETCH is ignored; oFetchReq is 0 in ISSUE and SPLIT.

Reset
REQ-031 When iReset_n=0 at a rising edge: state <= FETCH, oPC=0x0000, oIR=0, oIssueValid=0, oSlotMask=2'b00, oFetchReq=0.
REQ-032 The first fetch request (address 0x0000) is asserted in the first cycle after iReset_n returns high.
REQ-033 Reset mid-fetch or mid-split abandons the operation; no issue follows for the abandoned packet.

Configuration
REQ-034 Macro EMBERTRAIL_HAZARD_SPLIT_EN defined: hazard detection and the SPLIT state are implemented per REQ-019..REQ-028.
REQ-035 Macro EMBERTRAIL_HAZARD_SPLIT_EN undefined: hazard is constant 0 and SPLIT is unreachable; dual non-extended packets always issue with mask 2'b11.

Verification
REQ-036 Reset release, ack on 2nd cycle with 0x0000_0001 -> oIR=0x00000001, mask 01, then oFetchAddr=0x0001.
REQ-037 Packet 0x0012_8021 at PC 0x0010 (slot 1 ADDR r2; dual; slot 2 ADDR r1,r0; no hazard) -> mask 11, next fetch 0x0012.
REQ-038 Packet 0x0022_8021 (slot 2 A2=r2) with macro defined -> mask 01, then mask 10 with the same IR, then PC+2; with macro undefined -> single issue, mask 11.
REQ-039 BEQ packet 0x0040_000F, iBranchTaken=1, target 0x0100 at accept -> next oFetchAddr=0x0100, no SPLIT.
REQ-040 iStall=1 for 3 cycles in ISSUE -> oIR, mask and PC stable; the accept occurs on the cycle iStall falls.
REQ-041 oPC=0xFFFF with a dual packet -> next oFetchAddr=0x0001.
